// File: rtl/regbank_io_pkg.sv
// Shared types and constants for the board-input register-bank writer.
// Holds the FSM state encoding, the default debounce length and the write counter width.
package regbank_io_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int WRITE_COUNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/regbank_input_writer_btn_debouncer.sv
// Two-flop synchroniser plus debounce counter for a raw push-button.
// db_level_o only changes after DEBOUNCE_CYCLES consecutive samples that disagree with it.
module btn_debouncer
    import regbank_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock_50Mhz,
    input  logic reset,
    input  logic btn_i,
    output logic db_level_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample that agrees with the accepted level restarts the run.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= btn_i;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_level_o = db_q;

endmodule

// File: rtl/regbank_input_writer.sv
// Board-input front end: one registered register-bank write (we3/A3/WD3) per debounced press.
// Build option ADDR_AUTO_INC_EN: writes after the first one since reset use the previous A3 + 1.
module regbank_input_writer
    import regbank_io_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int SIZE            = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                     clock_50Mhz,
    input  logic                     reset,
    input  logic                     btn_write,
    input  logic [SIZE-1:0]          sw_addr,
    input  logic [WIDTH-1:0]         sw_data,
    output logic                     we3,
    output logic [SIZE-1:0]          A3,
    output logic [WIDTH-1:0]         WD3,
    output logic                     busy,
    output logic [WRITE_COUNT_W-1:0] write_count
);

    logic                     db_level;
    wr_state_e                state_q;
    wr_state_e                state_d;
    logic                     we3_q;
    logic                     we3_d;
    logic [SIZE-1:0]          a3_q;
    logic [SIZE-1:0]          a3_d;
    logic [WIDTH-1:0]         wd3_q;
    logic [WIDTH-1:0]         wd3_d;
    logic [WRITE_COUNT_W-1:0] count_q;
    logic [WRITE_COUNT_W-1:0] count_d;
    logic [SIZE-1:0]          next_addr;
`ifdef ADDR_AUTO_INC_EN
    logic                     first_q;
    logic                     first_d;
`endif

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock_50Mhz(clock_50Mhz),
        .reset      (reset),
        .btn_i      (btn_write),
        .db_level_o (db_level)
    );

`ifdef ADDR_AUTO_INC_EN
    assign next_addr = first_q ? sw_addr : a3_q + SIZE'(1);
`else
    assign next_addr = sw_addr;
`endif

    // HOLD only exits on a released level, so a high level seen in IDLE is always a fresh press.
    always_comb begin
        state_d = state_q;
        we3_d   = 1'b0;
        a3_d    = a3_q;
        wd3_d   = wd3_q;
        count_d = count_q;
`ifdef ADDR_AUTO_INC_EN
        first_d = first_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (db_level) begin
                    state_d = WRITE;
                    we3_d   = 1'b1;
                    a3_d    = next_addr;
                    wd3_d   = sw_data;
`ifdef ADDR_AUTO_INC_EN
                    first_d = 1'b0;
`endif
                end
            end
            WRITE: begin
                state_d = HOLD;
                count_d = count_q + WRITE_COUNT_W'(1);
            end
            HOLD: begin
                if (!db_level) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we3_q   <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
            count_q <= '0;
`ifdef ADDR_AUTO_INC_EN
            first_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            we3_q   <= we3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            count_q <= count_d;
`ifdef ADDR_AUTO_INC_EN
            first_q <= first_d;
`endif
        end
    end

    assign we3         = we3_q;
    assign A3          = a3_q;
    assign WD3         = wd3_q;
    assign busy        = (state_q != IDLE);
    assign write_count = count_q;

endmodule

// File: tb/tb_regbank_input_writer.sv
// Bench for regbank_input_writer with DEBOUNCE_CYCLES=4: cycle-exact vector table plus
// hand-written sequences for long holds, address latching, reset mid-write and counter wrap.
module tb_regbank_input_writer;

    logic       clock_50Mhz = 1'b0;
    logic       reset       = 1'b1;
    logic       btn_write   = 1'b0;
    logic [1:0] sw_addr     = '0;
    logic [2:0] sw_data     = '0;
    logic       we3;
    logic [1:0] A3;
    logic [2:0] WD3;
    logic       busy;
    logic [7:0] write_count;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    typedef struct {
        logic       btn;
        logic [1:0] addr;
        logic [2:0] data;
        logic       we3;
        logic [1:0] a3;
        logic [2:0] wd3;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];

    regbank_input_writer #(
        .WIDTH          (3),
        .SIZE           (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock_50Mhz(clock_50Mhz),
        .reset      (reset),
        .btn_write  (btn_write),
        .sw_addr    (sw_addr),
        .sw_data    (sw_data),
        .we3        (we3),
        .A3         (A3),
        .WD3        (WD3),
        .busy       (busy),
        .write_count(write_count)
    );

    always #10 clock_50Mhz = ~clock_50Mhz;

    always @(negedge clock_50Mhz) begin
        if (we3 === 1'b1) pulses <= pulses + 1;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock_50Mhz);
    endtask

    task automatic applyStimulus(input logic btn, input logic [1:0] addr, input logic [2:0] data);
        btn_write = btn;
        sw_addr   = addr;
        sw_data   = data;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic b, input logic [1:0] ad, input logic [2:0] d,
                          input logic w, input logic [1:0] a, input logic [2:0] wd,
                          input logic bs, input logic [7:0] c);
        vec_t v;
        v.btn = b; v.addr = ad; v.data = d;
        v.we3 = w; v.a3 = a; v.wd3 = wd; v.busy = bs; v.cnt = c;
        vq.push_back(v);
    endtask

    task automatic pulseReset();
        applyStimulus(1'b0, sw_addr, sw_data);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] expA;
        int         p0;
        int         waited;

        // Bounce: 3 high, 1 low, 2 high, low -- never four agreeing samples.
        addVec(1, 0, 0, 0, 0, 0, 0, 0); addVec(1, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0); addVec(0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0); addVec(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) addVec(0, 0, 0, 0, 0, 0, 0, 0);
        // Clean press addr=2 data=5 from edge N: write pulse after edge N+6, data change ignored.
        for (int i = 0; i < 6; i++) addVec(1, 2, 5, 0, 0, 0, 0, 0);
        addVec(1, 2, 5, 1, 2, 5, 1, 0);
        addVec(1, 2, 1, 0, 2, 5, 1, 1);
        for (int i = 0; i < 6; i++) addVec(0, 2, 1, 0, 2, 5, 1, 1);
        addVec(0, 2, 1, 0, 2, 5, 0, 1);
        addVec(0, 2, 1, 0, 2, 5, 0, 1);

        tick(2);
        checkOutput("reset_state", {we3, A3, WD3, busy, write_count}, 32'd0);
        reset = 1'b0;

        foreach (vq[i]) begin
            applyStimulus(vq[i].btn, vq[i].addr, vq[i].data);
            tick(1);
            checkOutput($sformatf("vec%0d", i), {we3, A3, WD3, busy, write_count},
                        {vq[i].we3, vq[i].a3, vq[i].wd3, vq[i].busy, vq[i].cnt});
        end

        // Long hold with data change mid-hold: exactly one write of the original data.
        p0 = pulses;
        applyStimulus(1'b1, 2'd1, 3'd5);
        for (int i = 0; i < 100; i++) begin
            if (i == 20) sw_data = 3'd7;
            tick(1);
        end
        checkOutput("hold_pulses", pulses - p0, 1);
        checkOutput("hold_wd3", WD3, 3'd5);
        checkOutput("hold_count", write_count, 8'd2);
        applyStimulus(1'b0, 2'd1, 3'd7);
        tick(15);
        checkOutput("release_busy", busy, 1'b0);
        applyStimulus(1'b1, 2'd1, 3'd7);
        tick(15);
        checkOutput("second_wd3", WD3, 3'd7);
        checkOutput("second_count", write_count, 8'd3);
        checkOutput("second_busy", busy, 1'b1);
        applyStimulus(1'b0, 2'd1, 3'd7);
        tick(15);

        // Address source across three presses after a reset.
        pulseReset();
        expA = 2'd3;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd3, 3'(i + 1));
            tick(12);
            checkOutput($sformatf("addr_press%0d", i), A3, expA);
            applyStimulus(1'b0, 2'd3, 3'd0);
            tick(12);
`ifdef ADDR_AUTO_INC_EN
            expA = expA + 2'd1;
`endif
        end

        // Reset while we3 is high, button kept pressed through release.
        applyStimulus(1'b1, 2'd2, 3'd6);
        waited = 0;
        while (we3 !== 1'b1 && waited < 50) begin
            tick(1);
            waited++;
        end
        checkOutput("midop_we3_seen", we3, 1'b1);
        #2 reset = 1'b1;
        #1 checkOutput("midop_abort", {we3, A3, WD3, busy, write_count}, 32'd0);
        tick(2);
        p0 = pulses;
        reset = 1'b0;
        tick(30);
        checkOutput("held_rearm_pulses", pulses - p0, 1);
        checkOutput("held_rearm_regs", {A3, WD3, write_count}, {2'd2, 3'd6, 8'd1});
        applyStimulus(1'b0, 2'd2, 3'd6);
        tick(15);

        // 256 press/release pairs wrap the write counter.
        pulseReset();
        p0 = pulses;
        for (int n = 0; n < 256; n++) begin
            applyStimulus(1'b1, 2'd1, 3'(n));
            tick(10);
            applyStimulus(1'b0, 2'd1, 3'(n));
            tick(10);
            if (n == 254) checkOutput("count_255", write_count, 8'd255);
        end
        checkOutput("count_wrap", write_count, 8'd0);
        checkOutput("wrap_pulses", pulses - p0, 256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
